// File: rtl/ppi_pkg.sv
// Shared helpers for the polyphase interpolator blocks: FSM states, width
// arithmetic and the round/shift/saturate step applied to every phase result.
package ppi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } ppi_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // One guard bit minimum so a single-tap bank still has headroom for rounding.
  function automatic int acc_width(input int idata_w, input int coeff_w, input int taps);
    return idata_w + coeff_w + ((clog2(taps) == 0) ? 1 : clog2(taps));
  endfunction

  // Round half up, arithmetic shift, then clamp to a signed out_w range.
  // Worked in 64 bits so the rounding add cannot wrap for any legal accumulator.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                   input int shift, input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = v;
    if (shift > 0) r = (v + (64'sd1 <<< (shift - 1))) >>> shift;
    if (out_w >= 64) return r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/ppi_mac.sv
// Registered signed multiply-accumulate; 'first' restarts the sum from the
// current product. 'sum' is the combinational next value used for the last tap.
module ppi_mac #(
  parameter int gp_a_width   = 16,
  parameter int gp_b_width   = 16,
  parameter int gp_acc_width = 33
) (
  input  logic                           i_clk,
  input  logic                           i_rst_an,
  input  logic                           en,
  input  logic                           first,
  input  logic signed [gp_a_width-1:0]   a,
  input  logic signed [gp_b_width-1:0]   b,
  output logic signed [gp_acc_width-1:0] acc,
  output logic signed [gp_acc_width-1:0] sum
);

  localparam int PROD_W = gp_a_width + gp_b_width;

  logic signed [PROD_W-1:0]       prod;
  logic signed [gp_acc_width-1:0] prod_ext;
  logic signed [gp_acc_width-1:0] base;

  assign prod     = a * b;
  assign prod_ext = {{(gp_acc_width - PROD_W){prod[PROD_W-1]}}, prod};
  assign base     = first ? '0 : acc;
  assign sum      = base + prod_ext;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an)  acc <= '0;
    else if (en)    acc <= sum;
  end

endmodule

// File: rtl/ppi_polyphase_bank.sv
// Time-multiplexed polyphase FIR bank: one shared MAC evaluates all L phases of
// N taps per accepted sample and presents them as one packed bus, phase p in slot p.
//
//   state   | meaning
//   IDLE    | waiting for i_valid; accepting shifts the delay line
//   MAC     | one product per cycle, tap inside phase
//   DONE    | holding registers copied to o_data, o_valid strobe
module ppi_polyphase_bank
  import ppi_pkg::*;
#(
  parameter int gp_idata_width          = 16,
  parameter int gp_coeff_width          = 16,
  parameter int gp_odata_width          = 26,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_nr_taps              = 2,
  parameter logic [gp_interpolation_factor*gp_nr_taps*gp_coeff_width-1:0] gp_coeffs = '0,
  parameter int gp_shift                = 0
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_an,
  input  logic                                         i_ena,
  input  logic                                         i_valid,
  input  logic signed [gp_idata_width-1:0]             i_data,
  output logic [gp_interpolation_factor*gp_odata_width-1:0] o_data,
  output logic                                         o_valid,
  output logic                                         o_busy,
  output logic                                         o_overrun
);

  localparam int L  = gp_interpolation_factor;
  localparam int N  = gp_nr_taps;
  localparam int OW = gp_odata_width;
  localparam int AW = acc_width(gp_idata_width, gp_coeff_width, N);
  localparam int PW = clog2(L);
  localparam int KW = (clog2(N) == 0) ? 1 : clog2(N);
  localparam int IW = clog2(L * N);

  ppi_state_t state_q, state_d;
  logic accept, mac_step, done, last_tap, last_phase;

  logic [PW-1:0] phase_q;
  logic [KW-1:0] tap_q;
  logic [IW-1:0] h_idx;

  logic signed [gp_idata_width-1:0] dline_q [N];
  logic signed [gp_idata_width-1:0] x_sel;
  logic signed [gp_coeff_width-1:0] h_sel;
  logic signed [AW-1:0]             acc, sum;
  logic [OW-1:0]                    y_phase;
  logic [L*OW-1:0]                  hold_q;

  assign last_tap   = (tap_q == KW'(N - 1));
  assign last_phase = (phase_q == PW'(L - 1));
  assign o_busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mac_step = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: if (i_valid) begin
        accept  = 1'b1;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        mac_step = 1'b1;
        if (last_tap && last_phase) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an)  state_q <= ST_IDLE;
    else if (i_ena) state_q <= state_d;
  end

  // Phase p, tap k uses prototype coefficient h[p + k*L].
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      phase_q <= '0;
      tap_q   <= '0;
    end else if (i_ena) begin
      if (accept) begin
        phase_q <= '0;
        tap_q   <= '0;
      end else if (mac_step) begin
        if (last_tap) begin
          tap_q   <= '0;
          phase_q <= phase_q + 1'b1;
        end else begin
          tap_q <= tap_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      for (int i = 0; i < N; i++) dline_q[i] <= '0;
    end else if (i_ena && accept) begin
      dline_q[0] <= i_data;
      for (int i = 1; i < N; i++) dline_q[i] <= dline_q[i-1];
    end
  end

  assign h_idx   = IW'(phase_q) + IW'(tap_q) * IW'(L);
  assign h_sel   = gp_coeffs[h_idx*gp_coeff_width +: gp_coeff_width];
  assign x_sel   = dline_q[tap_q];
  assign y_phase = OW'(round_sat(64'(sum), gp_shift, OW));

  ppi_mac #(
    .gp_a_width   (gp_idata_width),
    .gp_b_width   (gp_coeff_width),
    .gp_acc_width (AW)
  ) u_mac (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .en       (i_ena && mac_step),
    .first    (tap_q == '0),
    .a        (x_sel),
    .b        (h_sel),
    .acc      (acc),
    .sum      (sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an)                         hold_q <= '0;
    else if (i_ena && mac_step && last_tap) hold_q[phase_q*OW +: OW] <= y_phase;
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (i_ena) begin
      o_valid <= done;
      if (done) o_data <= hold_q;
      if (i_valid && state_q != ST_IDLE) o_overrun <= 1'b1;
    end
  end

endmodule
